// File: rtl/demux_1_8_bit_collector.sv
// Registered 1-to-N bit demultiplexer: scatters a bit stream into an N-bit word
// (explicit select or auto-incrementing index), then offers the word via valid/ready.
module demux_1_8_bit_collector #(
  parameter int unsigned SEL_W = 3,
  localparam int unsigned N = 1 << SEL_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] select,
  input  logic             auto_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out,
  output logic [N-1:0]     written_mask,
  output logic             dup_err
);

  typedef enum logic {COLLECT, HOLD} state_e;

  state_e           state_q,     state_d;
  logic [N-1:0]     out_q,       out_d;
  logic [N-1:0]     mask_q,      mask_d;
  logic [SEL_W-1:0] cnt_q,       cnt_d;
  logic             mode_q,      mode_d;
  logic             dup_q,       dup_d;
  logic             in_ready_q,  in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             accept_c;
  logic             mode_eff_c;
  logic [SEL_W-1:0] idx_c;

  assign accept_c   = in_valid & in_ready_q;
  // First bit of a frame sees the live auto_mode; later bits use the latched mode.
  assign mode_eff_c = (mask_q == '0) ? auto_mode : mode_q;
  assign idx_c      = mode_eff_c ? cnt_q : select;

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    dup_d       = dup_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      COLLECT: begin
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        if (accept_c) begin
          if (mask_q == '0) mode_d = auto_mode;
          if (mask_q[idx_c]) dup_d = 1'b1;
          out_d[idx_c]  = in_bit;
          mask_d[idx_c] = 1'b1;
          if (mode_eff_c) cnt_d = cnt_q + SEL_W'(1);
          if (&mask_d) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      HOLD: begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b1;
        if (out_valid_q && out_ready) begin
          mask_d      = '0;
          cnt_d       = '0;
          state_d     = COLLECT;
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= COLLECT;
      out_q       <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      dup_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      dup_q       <= dup_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out          = out_q;
  assign written_mask = mask_q;
  assign dup_err      = dup_q;

endmodule

// File: tb/tb_demux_1_8_bit_collector.sv
// Directed bench for demux_1_8_bit_collector with hand-computed expectations.
module tb_demux_1_8_bit_collector;

  logic       clock = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic [2:0] select;
  logic       auto_mode;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic [7:0] written_mask;
  logic       dup_err;

  int vectors    = 0;
  int miscompares = 0;

  demux_1_8_bit_collector #(.SEL_W(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bit       (in_bit),
    .select       (select),
    .auto_mode    (auto_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out          (out),
    .written_mask (written_mask),
    .dup_err      (dup_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs and outputs are handled 1 time unit after the edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] bits1;
    logic [2:0] sel2 [8];
    logic [2:0] sel3 [7];
    logic [7:0] m;
    logic [7:0] bits5;

    bits1 = 8'b0100_1101;
    sel2  = '{3'd7, 3'd3, 3'd0, 3'd5, 3'd1, 3'd6, 3'd2, 3'd4};
    sel3  = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    bits5 = 8'hAB;

    reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; select = 3'd0;
    auto_mode = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_out", out, 8'h00);
    check("rst_mask", written_mask, 8'h00);
    check("rst_out_valid", {7'd0, out_valid}, 8'h00);
    check("rst_dup", {7'd0, dup_err}, 8'h00);
    reset = 1'b1;
    cyc();
    check("post_rst_in_ready", {7'd0, in_ready}, 8'h01);

    // Auto frame: bits land at index 0..7 in order.
    auto_mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_bit = bits1[i];
      cyc();
      if (i == 6) check("auto_no_valid_early", {7'd0, out_valid}, 8'h00);
    end
    in_valid = 1'b0;
    check("auto_out", out, 8'h4D);
    check("auto_out_valid", {7'd0, out_valid}, 8'h01);
    check("auto_hold_in_ready", {7'd0, in_ready}, 8'h00);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("auto_release_mask", written_mask, 8'h00);
    check("auto_release_valid", {7'd0, out_valid}, 8'h00);
    check("auto_release_in_ready", {7'd0, in_ready}, 8'h01);

    // Manual permutation, ones only at 7 and 0.
    auto_mode = 1'b0; in_valid = 1'b1; m = 8'h00;
    for (int i = 0; i < 8; i++) begin
      select = sel2[i];
      in_bit = (sel2[i] == 3'd7 || sel2[i] == 3'd0);
      m[sel2[i]] = 1'b1;
      cyc();
      check("man_mask_step", written_mask, m);
    end
    in_valid = 1'b0;
    check("man_out", out, 8'h81);
    check("man_out_valid", {7'd0, out_valid}, 8'h01);
    check("man_dup", {7'd0, dup_err}, 8'h00);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("man_release_valid", {7'd0, out_valid}, 8'h00);

    // Manual duplicate at index 2.
    in_valid = 1'b1; select = 3'd2; in_bit = 1'b0;
    cyc();
    check("dup_first", {7'd0, dup_err}, 8'h00);
    in_bit = 1'b1;
    cyc();
    check("dup_second", {7'd0, dup_err}, 8'h01);
    check("dup_mask", written_mask, 8'h04);
    in_bit = 1'b0;
    for (int i = 0; i < 7; i++) begin
      select = sel3[i];
      cyc();
      if (i == 5) check("dup_not_done", {7'd0, out_valid}, 8'h00);
    end
    check("dup_out", out, 8'h04);
    check("dup_out_valid", {7'd0, out_valid}, 8'h01);

    // Stall in HOLD with producer still pushing.
    select = 3'd1;
    for (int i = 0; i < 5; i++) begin
      in_bit = ~in_bit;
      cyc();
      check("stall_out", out, 8'h04);
      check("stall_valid", {7'd0, out_valid}, 8'h01);
      check("stall_mask", written_mask, 8'hFF);
      check("stall_in_ready", {7'd0, in_ready}, 8'h00);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("stall_release_valid", {7'd0, out_valid}, 8'h00);
    check("stall_release_in_ready", {7'd0, in_ready}, 8'h01);
    check("stall_release_mask", written_mask, 8'h00);

    // Auto frame with auto_mode dropped mid-frame: mode stays latched.
    auto_mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        auto_mode = 1'b0;
        select = 3'd7;
      end
      in_bit = bits5[i];
      cyc();
      if (i == 3) check("latch_mask4", written_mask, 8'h0F);
    end
    in_valid = 1'b0;
    check("latch_out", out, 8'hAB);
    check("latch_valid", {7'd0, out_valid}, 8'h01);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    in_valid = 1'b1; select = 3'd5; in_bit = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("next_frame_manual", written_mask, 8'h20);

    // Async reset mid-frame after 4 auto accepts.
    reset = 1'b0;
    #3;
    reset = 1'b1;
    cyc();
    auto_mode = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    in_valid = 1'b0;
    check("pre_rst_mask", written_mask, 8'h0F);
    #2;
    reset = 1'b0;
    #1;
    check("async_out", out, 8'h00);
    check("async_mask", written_mask, 8'h00);
    check("async_valid", {7'd0, out_valid}, 8'h00);
    check("async_dup", {7'd0, dup_err}, 8'h00);
    #1;
    reset = 1'b1;
    cyc();
    in_valid = 1'b1; in_bit = 1'b1;
    cyc();
    in_valid = 1'b0;
    check("restart_mask", written_mask, 8'h01);
    check("restart_out", out, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux_1_8_bit_collector.md
Name: demux_1_8_bit_collector

Overview:
Registered 1-to-N bit demultiplexer: the inverse of the one-bit select muxes in the multdiv datapath. It scatters a stream of single bits into an N-bit register, either at an explicit select index (manual mode) or at an internal auto-incrementing index (auto mode). Once all N positions are written, it presents the assembled word downstream with a valid/ready handshake. It sits between bit-serial producers (bit-per-cycle multdiv control and quotient bits) and word-wide consumers.

Parameters:
SEL_W, 3, select/index width; N = 2**SEL_W output bits (default 8)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
in_valid  input  1  producer has a bit this cycle
in_ready  output  1  block can accept a bit this cycle
in_bit  input  1  data bit
select  input  SEL_W  target index (used in manual mode only)
auto_mode  input  1  1 = auto index, 0 = use select; sampled at frame start only
out_valid  output  1  assembled word available
out_ready  input  1  consumer accepts word
out  output  N  assembled word
written_mask  output  N  bit i = 1 when position i has been written this frame
dup_err  output  1  sticky: manual write hit an already-written position

Behaviour:
- Reset (reset=0, async, any time including mid-frame): out=0, written_mask=0, out_valid=0, dup_err=0, index counter=0, latched mode=0, state=COLLECT. in_ready is 1 one cycle after reset deasserts.
- Accept = in_valid & in_ready, evaluated on the rising clock edge.
- States:
  - COLLECT: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Mode latch: on an accept with written_mask==0, mode_q <= auto_mode. That first bit uses the new mode. auto_mode is ignored for the rest of the frame.
- Target index: the index counter if mode is auto, else select. For the first bit of a frame, the effective mode is auto_mode.
- On accept:
  - out[idx] <= in_bit and written_mask[idx] <= 1.
  - In auto mode, the counter increments, wrapping N-1 -> 0.
  - Other out bits hold their values.
- Manual duplicate: accepting at an index whose mask bit is already 1 overwrites the data and sets dup_err (sticky until reset). The mask is unchanged. This write does not by itself complete the frame.
- Completion: when an accept makes written_mask all ones, the next state is HOLD. out_valid rises the cycle after the last accept (latency 1). out is stable throughout HOLD.
- HOLD, when out_valid & out_ready at the edge:
  - written_mask <= 0, counter <= 0, next state COLLECT.
  - out keeps its last value, is not cleared, and is overwritten bit by bit in the next frame.
  - in_ready rises the cycle after the handshake, so there is no same-cycle accept and release.
- HOLD with out_ready=0: hold indefinitely, with out and out_valid stable. in_valid is ignored because in_ready=0.
- Manual mode does not need ascending order; any permutation of the N indices completes the frame.
- Minimum throughput: N+1 cycles per word (N accepts plus 1 HOLD cycle with out_ready tied high).
- X on select when not accepting, or while in auto mode, has no effect.

Test Plan:
- Auto mode, in_valid=1 for 8 cycles, bits 1,0,1,1,0,0,1,0 -> index0 first, so out=8'b0100_1101. out_valid rises the cycle after the 8th accept. in_ready=0 during HOLD. out_ready=1 -> mask=0, in_ready=1 next cycle.
- Manual mode, selects 7,3,0,5,1,6,2,4 with in_bit=1 only for selects 7 and 0 -> out=8'h81, written_mask steps to 8'hFF, out_valid=1, dup_err=0.
- Manual mode, select=2 twice (bits 0 then 1), then the remaining 7 indices with bits 0 -> dup_err=1 after the second write, out=8'h04, completion only after the 8th distinct index.
- HOLD with out_ready=0 for 5 cycles while in_valid=1 with toggling in_bit -> out, out_valid and written_mask unchanged, in_ready=0. Then out_ready=1 -> COLLECT next cycle.
- Auto frame with auto_mode toggled to 0 after 3 accepts and select=7 driven -> bits still land at indices 3..7 in order and the frame completes on the 8th accept. The next frame's first accept latches manual mode.
- reset pulsed low asynchronously mid-edge after 4 auto accepts -> out=0, mask=0, out_valid=0 and dup_err=0 immediately. The next frame starts at index 0.
